// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: three debounced push buttons (start/stop, clear, direction)
// controlling a modulo-MOD up/down counter that advances on a prescaled tick.
`timescale 1ns/1ps
module stopwatch_ctrl #(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned MOD          = 16,
  parameter int unsigned TICK_DIV     = 125000000,
  parameter int unsigned DEB_DIV      = 1250000,
  parameter int unsigned DEB_SAMPLES  = 2,
  parameter int unsigned RUN_AT_RESET = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       btn,
  output logic [CNT_W-1:0] ld,
  output logic             running,
  output logic             dir_down,
  output logic             wrap
);

  localparam int unsigned NBTN   = 3;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DEB_W  = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

  localparam logic [CNT_W-1:0]  LD_MAX    = CNT_W'(MOD - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_DIV - 1);
  localparam logic              RUN_RST   = (RUN_AT_RESET != 0);

  logic [NBTN-1:0]                  sync1, sync2;
  logic [DEB_W-1:0]                 deb_cnt;
  logic                             deb_strobe_c;
  logic [NBTN-1:0][DEB_SAMPLES-1:0] win, win_nxt_c;
  logic [NBTN-1:0]                  stable, stable_nxt_c, stable_d, press_c;
  logic [TICK_W-1:0]                tick_cnt;
  logic                             tick_c;
  logic [CNT_W-1:0]                 ld_nxt_c;
  logic                             wrap_nxt_c, running_nxt_c, dir_down_nxt_c;

  // Two-flop synchronisers for the asynchronous button pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Free-running debounce sample strobe
  assign deb_strobe_c = (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            deb_cnt <= '0;
    else if (deb_strobe_c) deb_cnt <= '0;
    else                   deb_cnt <= deb_cnt + DEB_W'(1);
  end

  // Sample window shift and unanimous-vote level update
  always_comb begin
    win_nxt_c    = win;
    stable_nxt_c = stable;
    for (int unsigned i = 0; i < NBTN; i++) begin
      win_nxt_c[i][0] = sync2[i];
      for (int unsigned k = 1; k < DEB_SAMPLES; k++) begin
        win_nxt_c[i][k] = win[i][k-1];
      end
      if (deb_strobe_c) begin
        if (&win_nxt_c[i])       stable_nxt_c[i] = 1'b1;
        else if (~|win_nxt_c[i]) stable_nxt_c[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win      <= '0;
      stable   <= '0;
      stable_d <= '0;
    end else begin
      if (deb_strobe_c) win <= win_nxt_c;
      stable   <= stable_nxt_c;
      stable_d <= stable;
    end
  end

  assign press_c = stable & ~stable_d;

  // Count tick prescaler; clear restarts the phase
  assign tick_c = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  tick_cnt <= '0;
    else if (press_c[1] || tick_c) tick_cnt <= '0;
    else                         tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Counter control: clear beats tick; tick sees pre-toggle running/dir_down
  always_comb begin
    ld_nxt_c       = ld;
    wrap_nxt_c     = 1'b0;
    running_nxt_c  = running ^ press_c[0];
    dir_down_nxt_c = dir_down ^ press_c[2];
    if (press_c[1]) begin
      ld_nxt_c = '0;
    end else if (tick_c && running) begin
      if (!dir_down) begin
        if (ld == LD_MAX) begin
          ld_nxt_c   = '0;
          wrap_nxt_c = 1'b1;
        end else begin
          ld_nxt_c = ld + CNT_W'(1);
        end
      end else begin
        if (ld == '0) begin
          ld_nxt_c   = LD_MAX;
          wrap_nxt_c = 1'b1;
        end else begin
          ld_nxt_c = ld - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld       <= '0;
      running  <= RUN_RST;
      dir_down <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      ld       <= ld_nxt_c;
      running  <= running_nxt_c;
      dir_down <= dir_down_nxt_c;
      wrap     <= wrap_nxt_c;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: random button stimulus against a behavioural stopwatch
// model; expected outputs are queued per edge and compared by a monitor.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int CNT_W       = 4;
  localparam int MOD         = 12;
  localparam int TICK_DIV    = 10;
  localparam int DEB_DIV     = 4;
  localparam int DEB_SAMPLES = 3;

  typedef struct packed {
    logic [3:0] ld;
    logic       running;
    logic       dir_down;
    logic       wrap;
  } obs_t;

  logic             clk;
  logic             rst_n;
  logic [2:0]       btn;
  logic [CNT_W-1:0] ld;
  logic             running, dir_down, wrap;

  int vectors;
  int miscompares;

  stopwatch_ctrl #(
    .CNT_W(CNT_W), .MOD(MOD), .TICK_DIV(TICK_DIV), .DEB_DIV(DEB_DIV),
    .DEB_SAMPLES(DEB_SAMPLES), .RUN_AT_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .ld(ld), .running(running), .dir_down(dir_down), .wrap(wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded time limit (vectors=%0d)", vectors);
    $fatal(1);
  end

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got ld=%0d run=%b dir=%b wrap=%b, expected ld=%0d run=%b dir=%b wrap=%b",
               name, $time, act.ld, act.running, act.dir_down, act.wrap,
               exp.ld, exp.running, exp.dir_down, exp.wrap);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  obs_t     exp_q[$];
  bit [2:0] bq[$];       // button samples still travelling through the synchroniser
  int       cyc;         // edges since reset release
  int       tph;         // cycles since last tick or clear
  int       m_ld;
  bit       m_run, m_dir, m_wrap;
  bit       m_stable[3], m_stable_d[3], m_last[3];
  int       m_runlen[3]; // consecutive identical strobe samples
  bit       m_press[3];
  bit       m_tick, m_strobe;
  bit [2:0] m_synced;

  task automatic model_reset();
    bq.delete();
    bq.push_back(3'b000);
    bq.push_back(3'b000);
    cyc = 0; tph = 0;
    m_ld = 0; m_run = 1'b1; m_dir = 1'b0; m_wrap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_stable[i] = 1'b0; m_stable_d[i] = 1'b0;
      m_last[i] = 1'b0; m_runlen[i] = DEB_SAMPLES;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_synced = bq.pop_front();
      bq.push_back(btn);
      m_strobe = ((cyc % DEB_DIV) == DEB_DIV - 1);
      m_tick   = (tph == TICK_DIV - 1);
      for (int i = 0; i < 3; i++) m_press[i] = m_stable[i] && !m_stable_d[i];

      if (m_press[1]) begin
        m_ld = 0; m_wrap = 1'b0;
      end else if (m_tick && m_run) begin
        if (!m_dir) begin
          m_wrap = (m_ld == MOD - 1);
          m_ld   = (m_ld + 1) % MOD;
        end else begin
          m_wrap = (m_ld == 0);
          m_ld   = (m_ld + MOD - 1) % MOD;
        end
      end else begin
        m_wrap = 1'b0;
      end
      if (m_press[0]) m_run = !m_run;
      if (m_press[2]) m_dir = !m_dir;
      tph = m_press[1] ? 0 : (tph + 1) % TICK_DIV;

      for (int i = 0; i < 3; i++) begin
        m_stable_d[i] = m_stable[i];
        if (m_strobe) begin
          if (m_synced[i] == m_last[i]) m_runlen[i]++;
          else begin m_last[i] = m_synced[i]; m_runlen[i] = 1; end
          if (m_runlen[i] >= DEB_SAMPLES) m_stable[i] = m_last[i];
        end
      end
      cyc++;
      exp_q.push_back(obs_t'{ld: 4'(m_ld), running: m_run, dir_down: m_dir, wrap: m_wrap});
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    obs_t act, e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {ld, running, dir_down, wrap};
      check("cycle", act, e);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    obs_t act;
    bit [2:0] b;
    int hold, idle;
    vectors = 0; miscompares = 0;
    btn = 3'b000; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Free run from reset: one step per 10 edges, wrap on 11->0 at edge 120
    for (int n = 1; n <= 130; n++) begin
      @(posedge clk); #1;
      act = {ld, running, dir_down, wrap};
      if (n == 1)   check("reset_state", act, obs_t'{ld: 4'd0,  running: 1'b1, dir_down: 1'b0, wrap: 1'b0});
      if (n == 9)   check("pre_first_tick", act, obs_t'{ld: 4'd0, running: 1'b1, dir_down: 1'b0, wrap: 1'b0});
      if (n == 10)  check("first_tick", act, obs_t'{ld: 4'd1, running: 1'b1, dir_down: 1'b0, wrap: 1'b0});
      if (n == 110) check("count_11", act, obs_t'{ld: 4'd11, running: 1'b1, dir_down: 1'b0, wrap: 1'b0});
      if (n == 120) check("wrap_up", act, obs_t'{ld: 4'd0, running: 1'b1, dir_down: 1'b0, wrap: 1'b1});
      if (n == 121) check("wrap_width", act, obs_t'{ld: 4'd0, running: 1'b1, dir_down: 1'b0, wrap: 1'b0});
    end

    // Random presses, glitches and combinations
    for (int seg = 0; seg < 250; seg++) begin
      b[0] = ($urandom_range(0, 3) == 0);
      b[1] = ($urandom_range(0, 7) == 0);
      b[2] = ($urandom_range(0, 3) == 0);
      hold = $urandom_range(1, 30);
      idle = $urandom_range(10, 80);
      @(negedge clk); btn = b;
      repeat (hold) @(negedge clk);
      btn = 3'b000;
      repeat (idle) @(negedge clk);
    end

    // Asynchronous reset mid-cycle: outputs must clear without a clock edge
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    act = {ld, running, dir_down, wrap};
    check("async_reset", act, obs_t'{ld: 4'd0, running: 1'b1, dir_down: 1'b0, wrap: 1'b0});
    @(negedge clk); rst_n = 1'b1;

    for (int seg = 0; seg < 40; seg++) begin
      b = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 30);
      @(negedge clk); btn = b;
      repeat (hold) @(negedge clk);
      btn = 3'b000;
      repeat ($urandom_range(20, 60)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Parametrised debounced stopwatch/counter controller driving the board LEDs. It takes three raw push buttons and debounces each one over a configurable number of sampled periods. The buttons produce single-cycle press events for start/stop, clear and direction. A modulo-MOD counter advances on a free-running tick prescaler. The block sits between the board button pins and the LED/display outputs.

## Interface
- CNT_W, 4: counter width in bits.
- MOD, 16: counter modulus; count range 0..MOD-1. Legal range 2 <= MOD <= 2^CNT_W.
- TICK_DIV, 125000000: clk cycles per count tick (1 s at 125 MHz).
- DEB_DIV, 1250000: clk cycles per debounce sample strobe (10 ms).
- DEB_SAMPLES, 2: consecutive equal samples needed to change a debounced level. Legal range 1..8.
- RUN_AT_RESET, 1: value of `running` after reset.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- btn  in  3  raw buttons, active-high, asynchronous to clk: [0] start/stop, [1] clear, [2] direction
- ld  out  CNT_W  current count
- running  out  1  counter enabled
- dir_down  out  1  0 = count up, 1 = count down
- wrap  out  1  one-cycle pulse when the count wraps

## Operation
- Synchroniser: each btn bit passes through a 2-flop synchroniser before any use.
- Debounce strobe:
  - deb_cnt runs 0..DEB_DIV-1 and then returns to 0, free-running.
  - The strobe is the cycle where deb_cnt == DEB_DIV-1.
- Debounce filter, per button, on the strobe edge:
  - Shift the synchronised value into a DEB_SAMPLES-deep window.
  - If every entry of the updated window is equal, stable[i] takes that value. Otherwise stable[i] holds.
- Press event: press[i] = stable[i] & ~stable_d[i], where stable_d is stable delayed one clk. It is exactly one cycle wide. Releases generate no event.
- Tick:
  - tick_cnt runs 0..TICK_DIV-1 and then returns to 0, free-running regardless of `running`.
  - The tick is the cycle where tick_cnt == TICK_DIV-1.
- Control, evaluated on each clk edge with all terms taken from pre-edge register values:
  - press[0]: running <= ~running.
  - press[2]: dir_down <= ~dir_down.
  - press[1] (clear): ld <= 0, tick_cnt <= 0, wrap <= 0. Clear overrides any tick in the same cycle. It does not change running or dir_down.
  - Otherwise, on tick with running = 1:
    - Up (dir_down = 0): if ld == MOD-1 then ld <= 0 and wrap <= 1, else ld <= ld+1.
    - Down (dir_down = 1): if ld == 0 then ld <= MOD-1 and wrap <= 1, else ld <= ld-1.
  - All other cycles: ld holds and wrap <= 0.
- Simultaneous events:
  - Start/stop and tick in the same cycle: the tick uses the old `running`.
  - Direction and tick in the same cycle: the tick uses the old dir_down.
  - Any combination of the three press events applies all of them together, subject to clear's priority over the tick.
- Arithmetic: all count math is modulo MOD within CNT_W bits. Values >= MOD never appear on ld.

## Timing
- Reset (rst_n low, asynchronous): ld = 0, running = RUN_AT_RESET, dir_down = 0, wrap = 0. Also cleared: tick_cnt, deb_cnt, the synchronisers, the windows, stable and stable_d.
- Reset release: the first tick occurs TICK_DIV cycles after the first clk edge with rst_n high. Reset mid-count discards the prescaler phase.
- Press latency: after btn rises and stays high, press fires within 2 + DEB_SAMPLES×DEB_DIV + 1 cycles.
- Press-to-effect: ld, running and dir_down change on the edge that ends the press cycle.
- wrap: high for exactly the one cycle after the wrapping tick edge, coincident with the new ld value.
- Glitch rejection: a btn pulse shorter than (DEB_SAMPLES-1)×DEB_DIV cycles produces no event.

## Test plan
Bench parameters: CNT_W=4, MOD=12, TICK_DIV=10, DEB_DIV=4, DEB_SAMPLES=3.
- Reset, then free run for 130 cycles:
  - ld steps 0,1,…,11,0 with one step every 10 cycles.
  - The first increment is 10 cycles after release.
  - wrap pulses once, on 11→0.
- Hold btn[0] for 40 cycles, then release:
  - Exactly one press is produced and running goes 1→0.
  - ld freezes while tick_cnt keeps running.
  - A second press restores counting.
- Raw btn[1] glitch of 5 cycles: no press and ld unchanged. A clean 40-cycle press makes ld = 0, and the next increment follows 10 cycles later.
- Press btn[2] while ld = 1:
  - ld counts 1,0,11,10.
  - wrap pulses on the 0→11 step.
- Force press[1] on the same cycle as a tick with ld = 5: ld = 0 and wrap = 0.
- Force press[0] on a tick cycle with running = 1: ld increments once, then stops.
- Assert rst_n low mid-count with ld = 7 and dir_down = 1: all outputs return to their reset values immediately, with no clk edge required.
